// File: rtl/axi4_pkg.sv
// Shared types for the AXI4 word-storage slave.
//   resp_t     : AXI response codes used by BRESP/RRESP.
//   w_state_t  : write-channel FSM states.
//   r_state_t  : read-channel FSM states.
//   SIZE_WORD  : the only legal AxSIZE (4-byte beats).
package axi4_pkg;

  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_t;

  // Response code for a burst given its error flag.
  function automatic resp_t resp_of(input logic err);
    return err ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/axi4_slave_mem.sv
// Single-port synchronous word memory behind the AXI slave.
//   ACLK, ARESETn : clock and asynchronous active-low reset (read register only).
//   mem_en        : port enable for this cycle.
//   mem_we        : 1 = write mem_wdata to mem_addr, 0 = read mem_addr.
//   mem_addr      : word index.
//   mem_wdata     : write data.
//   mem_rdata     : read data, valid one cycle after a read is issued.
// Array contents are deliberately not reset.
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int MEM_AW     = $clog2(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  mem_en,
  input  logic                  mem_we,
  input  logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage array write port; no reset so the array maps onto RAM.
  always_ff @(posedge ACLK) begin
    if (mem_en && mem_we) begin
      mem_r[mem_addr] <= mem_wdata;
    end
  end

  // Registered read port; holds its value until the next read.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      mem_rdata <= '0;
    end else if (mem_en && !mem_we) begin
      mem_rdata <= mem_r[mem_addr];
    end
  end

endmodule

// File: rtl/axi4_slave.sv
// AXI4 slave (INCR bursts, word addressing) in front of axi4_slave_mem.
//   ACLK, ARESETn          : clock, asynchronous active-low reset.
//   AW*/W*/B*              : write address, data and response channels.
//   AR*/R*                 : read address and data channels.
// Bursts with AxSIZE != 4 bytes or running past the last word are still
// fully handshaken but touch no memory and answer SLVERR. A write beat
// owns the memory port; a colliding read fetch waits one cycle.
module axi4_slave
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int MEM_AW = $clog2(DEPTH);
  localparam int AW1    = ADDR_WIDTH + 1;

  // One extra bit on the end address so start+len can never wrap.
  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [7:0]            len,
                                     input logic [2:0]            size);
    logic [AW1-1:0] last_s;
    last_s = {1'b0, addr} + AW1'(len);
    return (size != SIZE_WORD) || (last_s > AW1'(DEPTH - 1));
  endfunction

  w_state_t              w_state_r, w_state_n;
  logic [ADDR_WIDTH-1:0] waddr_r, waddr_n;
  logic [7:0]            wlen_r, wlen_n, wcnt_r, wcnt_n;
  logic                  werr_r, werr_n;
  resp_t                 bresp_r, bresp_n;
  logic                  awready_r, wready_r, bvalid_r;

  r_state_t              r_state_r, r_state_n;
  logic [ADDR_WIDTH-1:0] raddr_r, raddr_n;
  logic [7:0]            rlen_r, rlen_n, rcnt_r, rcnt_n;
  logic                  rerr_r, rerr_n;
  resp_t                 rresp_r, rresp_n;
  logic                  rlast_r, rlast_n;
  logic                  arready_r, rvalid_r;

  logic                  w_beat_s, w_mem_we_s, r_fetch_s;
  logic                  mem_en_s;
  logic [MEM_AW-1:0]     mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;
  logic                  unused_s;

  // WLAST is not needed: the beat count comes from AWLEN.
  assign unused_s   = WLAST;

  assign w_beat_s   = (w_state_r == W_DATA) && wready_r && WVALID;
  assign w_mem_we_s = w_beat_s && !werr_r;
  assign r_fetch_s  = (r_state_r == R_FETCH) && !rerr_r && !w_beat_s;
  assign mem_en_s   = w_mem_we_s || r_fetch_s;
  assign mem_addr_s = w_mem_we_s ? waddr_r[MEM_AW-1:0] : raddr_r[MEM_AW-1:0];

  assign AWREADY = awready_r;
  assign WREADY  = wready_r;
  assign BVALID  = bvalid_r;
  assign BRESP   = bresp_r;
  assign ARREADY = arready_r;
  assign RVALID  = rvalid_r;
  assign RRESP   = rresp_r;
  assign RLAST   = rlast_r;
  // Memory output register drives RDATA directly; error bursts force zero.
  assign RDATA   = rerr_r ? '0 : mem_rdata_s;

  // Write FSM state, burst context and registered channel outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_r <= W_IDLE;
      waddr_r   <= '0;
      wlen_r    <= 8'd0;
      wcnt_r    <= 8'd0;
      werr_r    <= 1'b0;
      bresp_r   <= OKAY;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
    end else begin
      w_state_r <= w_state_n;
      waddr_r   <= waddr_n;
      wlen_r    <= wlen_n;
      wcnt_r    <= wcnt_n;
      werr_r    <= werr_n;
      bresp_r   <= bresp_n;
      awready_r <= (w_state_n == W_IDLE);
      wready_r  <= (w_state_n == W_DATA);
      bvalid_r  <= (w_state_n == W_RESP);
    end
  end

  // Write FSM next state and burst bookkeeping.
  always_comb begin
    w_state_n = w_state_r;
    waddr_n   = waddr_r;
    wlen_n    = wlen_r;
    wcnt_n    = wcnt_r;
    werr_n    = werr_r;
    bresp_n   = bresp_r;
    case (w_state_r)
      W_IDLE: begin
        if (awready_r && AWVALID) begin
          waddr_n   = AWADDR;
          wlen_n    = AWLEN;
          wcnt_n    = 8'd0;
          werr_n    = burst_err(AWADDR, AWLEN, AWSIZE);
          w_state_n = W_DATA;
        end else begin
          w_state_n = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_beat_s) begin
          waddr_n = waddr_r + ADDR_WIDTH'(1);
          wcnt_n  = wcnt_r + 8'd1;
          if (wcnt_r == wlen_r) begin
            bresp_n   = resp_of(werr_r);
            w_state_n = W_RESP;
          end else begin
            w_state_n = W_DATA;
          end
        end else begin
          w_state_n = W_DATA;
        end
      end
      W_RESP: begin
        if (bvalid_r && BREADY) begin
          w_state_n = W_IDLE;
        end else begin
          w_state_n = W_RESP;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // Read FSM state, burst context and registered channel outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_r <= R_IDLE;
      raddr_r   <= '0;
      rlen_r    <= 8'd0;
      rcnt_r    <= 8'd0;
      rerr_r    <= 1'b0;
      rresp_r   <= OKAY;
      rlast_r   <= 1'b0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
    end else begin
      r_state_r <= r_state_n;
      raddr_r   <= raddr_n;
      rlen_r    <= rlen_n;
      rcnt_r    <= rcnt_n;
      rerr_r    <= rerr_n;
      rresp_r   <= rresp_n;
      rlast_r   <= rlast_n;
      arready_r <= (r_state_n == R_IDLE);
      rvalid_r  <= (r_state_n == R_DATA);
    end
  end

  // Read FSM next state: one fetch per beat, fetch yields to a write beat.
  always_comb begin
    r_state_n = r_state_r;
    raddr_n   = raddr_r;
    rlen_n    = rlen_r;
    rcnt_n    = rcnt_r;
    rerr_n    = rerr_r;
    rresp_n   = rresp_r;
    rlast_n   = rlast_r;
    case (r_state_r)
      R_IDLE: begin
        if (arready_r && ARVALID) begin
          raddr_n   = ARADDR;
          rlen_n    = ARLEN;
          rcnt_n    = 8'd0;
          rerr_n    = burst_err(ARADDR, ARLEN, ARSIZE);
          r_state_n = R_FETCH;
        end else begin
          r_state_n = R_IDLE;
        end
      end
      R_FETCH: begin
        // Error bursts never read memory, so they never need the port.
        if (rerr_r || !w_beat_s) begin
          rresp_n   = resp_of(rerr_r);
          rlast_n   = (rcnt_r == rlen_r);
          r_state_n = R_DATA;
        end else begin
          r_state_n = R_FETCH;
        end
      end
      R_DATA: begin
        if (rvalid_r && RREADY) begin
          if (rcnt_r == rlen_r) begin
            r_state_n = R_IDLE;
          end else begin
            rcnt_n    = rcnt_r + 8'd1;
            raddr_n   = raddr_r + ADDR_WIDTH'(1);
            r_state_n = R_FETCH;
          end
        end else begin
          r_state_n = R_DATA;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  axi4_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .MEM_AW     (MEM_AW)
  ) u_mem (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .mem_en    (mem_en_s),
    .mem_we    (w_mem_we_s),
    .mem_addr  (mem_addr_s),
    .mem_wdata (WDATA),
    .mem_rdata (mem_rdata_s)
  );

endmodule

// File: tb/tb_axi4_slave.sv
// Self-checking bench for axi4_slave: reset values, a table of directed
// bursts, backpressure holds, concurrent write/read, randomized bursts and
// a reset in the middle of a write burst. Expected data comes from a
// word-array model updated by the spec's burst rules.
module tb_axi4_slave;

  logic        ACLK;
  logic        ARESETn;
  logic [9:0]  AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [0:1023];

  typedef struct {
    bit          wr;
    int          addr;
    int          len;
    int          size;
    logic [31:0] d0;
    logic [1:0]  exp;
  } vec_t;
  vec_t vecs [15];

  axi4_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit exp_err(input int addr, input int len, input int size);
    return (size != 2) || (addr + len > 1023);
  endfunction

  function automatic logic [1:0] exp_resp(input bit e);
    return e ? 2'b10 : 2'b00;
  endfunction

  task automatic aw_phase(input int addr, input int len, input int size);
    int n;
    @(negedge ACLK);
    AWADDR = addr[9:0]; AWLEN = len[7:0]; AWSIZE = size[2:0]; AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) check("aw_timeout", 32'd0, 32'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic ar_phase(input int addr, input int len, input int size);
    int n;
    @(negedge ACLK);
    ARADDR = addr[9:0]; ARLEN = len[7:0]; ARSIZE = size[2:0]; ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) check("ar_timeout", 32'd0, 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d);
    int n;
    WDATA = d; WVALID = 1'b1;
    n = 0;
    while (WREADY !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) check("w_timeout", 32'd0, 32'd1);
    @(negedge ACLK);
    WVALID = 1'b0;
  endtask

  task automatic do_write(input int addr, input int len, input int size, input logic [31:0] d0,
                          input bit rnd, input int dly, output logic [1:0] resp);
    bit e;
    int n;
    logic [31:0] d;
    logic [1:0] er;
    e  = exp_err(addr, len, size);
    er = exp_resp(e);
    aw_phase(addr, len, size);
    for (int i = 0; i <= len; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) @(negedge ACLK);
      d = rnd ? $urandom : d0 * (i + 1);
      w_beat(d);
      if (!e) model[addr + i] = d;
    end
    n = 0;
    while (BVALID !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
    if (n >= 200) check("b_timeout", 32'd0, 32'd1);
    for (int i = 0; i < dly; i++) begin
      check("b_hold_valid", BVALID, 32'd1);
      check("b_hold_resp", BRESP, er);
      @(negedge ACLK);
    end
    resp = BRESP;
    check("bresp", BRESP, er);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input int addr, input int len, input int size, input int dly,
                         output logic [1:0] resp);
    bit e;
    int n;
    logic [31:0] ed;
    logic [1:0] er;
    e  = exp_err(addr, len, size);
    er = exp_resp(e);
    resp = 2'b11;
    ar_phase(addr, len, size);
    for (int i = 0; i <= len; i++) begin
      ed = e ? 32'd0 : model[addr + i];
      n = 0;
      while (RVALID !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
      if (n >= 200) check("r_timeout", 32'd0, 32'd1);
      for (int k = 0; k < dly; k++) begin
        check("r_hold_valid", RVALID, 32'd1);
        check("r_hold_data", RDATA, ed);
        check("r_hold_resp", RRESP, er);
        @(negedge ACLK);
      end
      check($sformatf("rdata@%0d", addr + i), RDATA, ed);
      check($sformatf("rresp@%0d", addr + i), RRESP, er);
      check($sformatf("rlast@%0d", addr + i), RLAST, (i == len) ? 32'd1 : 32'd0);
      resp = RRESP;
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_awready"}, AWREADY, 32'd0);
    check({tag, "_wready"},  WREADY,  32'd0);
    check({tag, "_bvalid"},  BVALID,  32'd0);
    check({tag, "_arready"}, ARREADY, 32'd0);
    check({tag, "_rvalid"},  RVALID,  32'd0);
    check({tag, "_bresp"},   BRESP,   32'd0);
    check({tag, "_rresp"},   RRESP,   32'd0);
    check({tag, "_rdata"},   RDATA,   32'd0);
    check({tag, "_rlast"},   RLAST,   32'd0);
  endtask

  initial begin
    logic [1:0] r1, r2;
    int a, l, s;

    ARESETn = 1'b0;
    AWADDR = 10'd0; AWLEN = 8'd0; AWSIZE = 3'd0; AWVALID = 1'b0;
    WDATA = 32'd0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = 10'd0; ARLEN = 8'd0; ARSIZE = 3'd0; ARVALID = 1'b0; RREADY = 1'b0;

    vecs[0]  = '{1'b1,    5, 0, 2, 32'hDEADBEEF, 2'b00};
    vecs[1]  = '{1'b0,    5, 0, 2, 32'h0,        2'b00};
    vecs[2]  = '{1'b1,  100, 3, 2, 32'h11,       2'b00};
    vecs[3]  = '{1'b0,  100, 3, 2, 32'h0,        2'b00};
    vecs[4]  = '{1'b1, 1022, 1, 2, 32'hA5A50001, 2'b00};
    vecs[5]  = '{1'b1, 1022, 3, 2, 32'h77,       2'b10};
    vecs[6]  = '{1'b0, 1022, 1, 2, 32'h0,        2'b00};
    vecs[7]  = '{1'b0, 1023, 0, 2, 32'h0,        2'b00};
    vecs[8]  = '{1'b1, 1023, 0, 2, 32'h00001234, 2'b00};
    vecs[9]  = '{1'b1,   10, 0, 2, 32'h0000CAFE, 2'b00};
    vecs[10] = '{1'b1,   10, 0, 1, 32'h99,       2'b10};
    vecs[11] = '{1'b0,   10, 0, 2, 32'h0,        2'b00};
    vecs[12] = '{1'b0,   10, 1, 3, 32'h0,        2'b10};
    vecs[13] = '{1'b0, 1020, 7, 2, 32'h0,        2'b10};
    vecs[14] = '{1'b0, 1023, 0, 2, 32'h0,        2'b00};

    // Reset values, then ready rises only on the first edge after release.
    @(negedge ACLK);
    check_idle_zero("reset");
    ARESETn = 1'b1;
    #1;
    check("awready_pre_edge", AWREADY, 32'd0);
    @(negedge ACLK);
    check("awready_post_rst", AWREADY, 32'd1);
    check("arready_post_rst", ARREADY, 32'd1);

    // Fill the whole memory so every later read has a known expectation.
    for (int b = 0; b < 4; b++) do_write(b * 256, 255, 2, 32'd0, 1'b1, 0, r1);

    // Directed table.
    for (int k = 0; k < 15; k++) begin
      if (vecs[k].wr) do_write(vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].d0, 1'b0, 0, r1);
      else            do_read(vecs[k].addr, vecs[k].len, vecs[k].size, 0, r1);
      check($sformatf("vec%0d_resp", k), r1, vecs[k].exp);
    end

    // Backpressure: response and read beats held for 5 cycles.
    do_write(700, 2, 2, 32'h0BAD0001, 1'b0, 5, r1);
    do_read(700, 2, 2, 5, r1);
    do_read(1020, 1, 7, 5, r1);

    // Concurrent write and read bursts on disjoint regions.
    fork
      do_write(400, 15, 2, 32'h0, 1'b1, 0, r1);
      do_read(600, 15, 2, 0, r2);
    join
    for (int k = 0; k < 6; k++) begin
      fork
        do_write($urandom_range(400, 560), $urandom_range(0, 31), 2, 32'h0, 1'b1,
                 $urandom_range(0, 2), r1);
        do_read($urandom_range(600, 760), $urandom_range(0, 31), 2, $urandom_range(0, 2), r2);
      join
    end
    do_read(400, 15, 2, 0, r1);

    // Randomized bursts, biased toward the top-of-memory bound and bad sizes.
    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(960, 1023) : $urandom_range(0, 1023);
      l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 31);
      s = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : 2;
      if ($urandom_range(0, 1) == 1) do_write(a, l, s, 32'h0, 1'b1, $urandom_range(0, 2), r1);
      else                           do_read(a, l, s, $urandom_range(0, 2), r1);
    end

    // Reset in the middle of a write: two beats land, the rest never do.
    aw_phase(300, 7, 2);
    w_beat(32'h11110001);
    model[300] = 32'h11110001;
    w_beat(32'h11110002);
    model[301] = 32'h11110002;
    #2;
    ARESETn = 1'b0;
    #1;
    check("midrst_awready", AWREADY, 32'd0);
    check("midrst_wready",  WREADY,  32'd0);
    check("midrst_bvalid",  BVALID,  32'd0);
    check("midrst_arready", ARREADY, 32'd0);
    check("midrst_rvalid",  RVALID,  32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check("midrst_awready_pre", AWREADY, 32'd0);
    @(negedge ACLK);
    check("midrst_awready_post", AWREADY, 32'd1);
    do_read(300, 7, 2, 0, r1);
    do_write(300, 0, 2, 32'h5555AAAA, 1'b0, 0, r1);
    check("post_rst_write_resp", r1, 32'd0);
    do_read(300, 0, 2, 0, r1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
